// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Control states of the serial sequencer
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } addsub_state_t;

    // Bits needed for a counter that must hold 0..width without wrapping
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/done handshake bundle for serial_addsub.
// Optional signed-overflow flag present when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout
`ifdef SERIAL_ADDSUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout
`ifdef SERIAL_ADDSUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_addsub_fa_cell.sv
// Behavioural one-bit full adder reused every cycle by the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH clocks.
// Subtraction is a + ~b + 1 (carry preset to 1). Optional signed overflow
// output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    addsub_state_t    state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             cout_r;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             c_msb_r;
    logic             ovf_r;
`endif

    logic             s_bit_s;
    logic             c_nxt_s;
    logic [WIDTH-1:0] sum_nxt_s;

    fa_cell u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (c_r),
        .s    (s_bit_s),
        .cout (c_nxt_s)
    );

    // Shift the new result bit into the MSB of the partial sum
    always_comb begin
        sum_nxt_s            = sum_r >> 1;
        sum_nxt_s[WIDTH-1]   = s_bit_s;
    end

    // Sequencer and datapath registers; busy trails the state by one cycle so
    // it stays high through the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            c_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            busy_r <= (state_r != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= S_RUN;
                        a_sr_r  <= bus.a;
                        b_sr_r  <= bus.b ^ {WIDTH{bus.sub}};
                        c_r     <= bus.sub;
                        cnt_r   <= {CW{1'b0}};
                        sum_r   <= {WIDTH{1'b0}};
`ifdef SERIAL_ADDSUB_OVF_EN
                        c_msb_r <= 1'b0;
                        ovf_r   <= 1'b0;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    done_r <= 1'b0;
                    a_sr_r <= a_sr_r >> 1;
                    b_sr_r <= b_sr_r >> 1;
                    sum_r  <= sum_nxt_s;
                    c_r    <= c_nxt_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
                        // carry entering the MSB cell on the final bit
                        c_msb_r <= c_r;
`endif
                    end else begin
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b1;
                    cout_r  <= c_r;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_r   <= c_msb_r ^ c_r;
`endif
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub at WIDTH 8, 1 and 16.
// Overflow checks are active when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8))  if8  ();
    serial_addsub_if #(.WIDTH(1))  if1  ();
    serial_addsub_if #(.WIDTH(16)) if16 ();

    serial_addsub #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_addsub #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_addsub #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t q8[$];
    res_t q1[$];
    res_t q16[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int dn8    = 0;
    int dn1    = 0;
    int dn16   = 0;
    int last1  = -1;
    int last16 = -1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b, input logic sub);
        res_t r;
        int   mask = (1 << w) - 1;
        int   half = 1 << (w - 1);
        int   ua   = int'(a) & mask;
        int   ub   = int'(b) & mask;
        int   sa   = (ua >= half) ? ua - (1 << w) : ua;
        int   sb   = (ub >= half) ? ub - (1 << w) : ub;
        int   ur   = sub ? ua - ub : ua + ub;
        int   sr   = sub ? sa - sb : sa + sb;
        r.sum  = 16'(ur & mask);
        r.cout = sub ? (ua >= ub) : (ur > mask);
        r.ovf  = (sr < -half) || (sr > half - 1);
        return r;
    endfunction

    // Single compare process: every done pulse is matched against the model queue
    always @(negedge clk) begin
        res_t e;
        cyc++;
        if (rst_n) begin
            if (if8.done) begin
                dn8++;
                check("u8 done_expected", 32'(q8.size() != 0), 32'd1);
                if (q8.size() != 0) begin
                    e = q8.pop_front();
                    check("u8 sum", 32'(if8.sum), 32'(e.sum));
                    check("u8 cout", 32'(if8.cout), 32'(e.cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                    check("u8 ovf", 32'(if8.ovf), 32'(e.ovf));
`endif
                end
            end
            if (if1.done) begin
                dn1++;
                if (last1 >= 0) check("u1 done_spacing", 32'(cyc - last1), 32'd3);
                last1 = cyc;
                check("u1 done_expected", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check("u1 sum", 32'(if1.sum), 32'(e.sum));
                    check("u1 cout", 32'(if1.cout), 32'(e.cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                    check("u1 ovf", 32'(if1.ovf), 32'(e.ovf));
`endif
                end
            end
            if (if16.done) begin
                dn16++;
                if (last16 >= 0) check("u16 done_spacing", 32'(cyc - last16), 32'd18);
                last16 = cyc;
                check("u16 done_expected", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e = q16.pop_front();
                    check("u16 sum", 32'(if16.sum), 32'(e.sum));
                    check("u16 cout", 32'(if16.cout), 32'(e.cout));
`ifdef SERIAL_ADDSUB_OVF_EN
                    check("u16 ovf", 32'(if16.ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Present one operation to the 8-bit unit; returns 1 time unit after the accepting edge
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub);
        if8.a     = a;
        if8.b     = b;
        if8.sub   = sub;
        if8.start = 1'b1;
        @(posedge clk);
        q8.push_back(model(8, {8'h00, a}, {8'h00, b}, sub));
        #1 if8.start = 1'b0;
    endtask

    // Bounded wait for the next done pulse of the 8-bit unit
    task automatic wait_done8();
        int d0 = dn8;
        int n  = 0;
        while (dn8 == d0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("u8 done_timeout", 32'(dn8 != d0), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t m;
        int   d0;
        if8.start = 1'b0;  if8.sub = 1'b0;  if8.a = 8'h00;   if8.b = 8'h00;
        if1.start = 1'b0;  if1.sub = 1'b0;  if1.a = 1'b0;    if1.b = 1'b0;
        if16.start = 1'b0; if16.sub = 1'b0; if16.a = 16'h0;  if16.b = 16'h0;

        // pin the reference model with hand-computed results
        m = model(8, 16'h00FF, 16'h0001, 1'b0);
        check("model ff+01", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b0, 1'b1, 16'h0000});
        m = model(8, 16'h0005, 16'h0007, 1'b1);
        check("model 05-07", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b0, 1'b0, 16'h00FE});
        m = model(8, 16'h007F, 16'h0001, 1'b0);
        check("model 7f+01", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b1, 1'b0, 16'h0080});
        m = model(8, 16'h0080, 16'h0001, 1'b1);
        check("model 80-01", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b1, 1'b1, 16'h007F});
        m = model(16, 16'h0000, 16'h0001, 1'b1);
        check("model16 0-1", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b0, 1'b0, 16'hFFFF});
        m = model(1, 16'h0001, 16'h0001, 1'b0);
        check("model1 1+1", {13'd0, m.ovf, m.cout, m.sum}, {13'd0, 1'b1, 1'b1, 16'h0000});

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", 32'(if8.busy), 32'd0);
        check("reset done", 32'(if8.done), 32'd0);
        check("reset sum", 32'(if8.sum), 32'd0);
        check("reset cout", 32'(if8.cout), 32'd0);
        check("reset sum16", 32'(if16.sum), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("reset ovf", 32'(if8.ovf), 32'd0);
`endif

        // 1: FF+01 with exact busy/done timing (k = cycles after the accepting edge)
        @(posedge clk);
        #1;
        op8(8'hFF, 8'h01, 1'b0);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("t1 busy c%0d", k), 32'(if8.busy), 32'((k >= 1) && (k <= 9)));
            check($sformatf("t1 done c%0d", k), 32'(if8.done), 32'(k == 9));
            if (k == 9) begin
                check("t1 sum", 32'(if8.sum), 32'h00);
                check("t1 cout", 32'(if8.cout), 32'd1);
            end
        end
        #1;

        // 2: subtraction with and without borrow
        op8(8'd5, 8'd7, 1'b1);
        wait_done8();
        check("t2 5-7 sum", 32'(if8.sum), 32'hFE);
        check("t2 5-7 cout", 32'(if8.cout), 32'd0);
        op8(8'd7, 8'd5, 1'b1);
        wait_done8();
        check("t2 7-5 sum", 32'(if8.sum), 32'h02);
        check("t2 7-5 cout", 32'(if8.cout), 32'd1);

        // 3: signed overflow boundaries
        op8(8'h7F, 8'h01, 1'b0);
        wait_done8();
        check("t3 7f+01 sum", 32'(if8.sum), 32'h80);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("t3 7f+01 ovf", 32'(if8.ovf), 32'd1);
`endif
        op8(8'h80, 8'h01, 1'b1);
        wait_done8();
        check("t3 80-01 sum", 32'(if8.sum), 32'h7F);
        check("t3 80-01 cout", 32'(if8.cout), 32'd1);
`ifdef SERIAL_ADDSUB_OVF_EN
        check("t3 80-01 ovf", 32'(if8.ovf), 32'd1);
`endif

        // 4: start pulses sampled at edges 3 and 9 of a running op are ignored
        d0 = dn8;
        op8(8'h12, 8'h34, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            if (k == 3 || k == 9) begin
                if8.a = 8'hFF; if8.b = 8'hFF; if8.sub = 1'b1; if8.start = 1'b1;
            end
            @(posedge clk);
            #1 if8.start = 1'b0;
        end
        check("t4 single done", 32'(dn8 - d0), 32'd1);
        check("t4 sum held", 32'(if8.sum), 32'h46);
        check("t4 cout held", 32'(if8.cout), 32'd0);
        check("t4 idle", 32'(if8.busy), 32'd0);

        // 5: asynchronous reset mid-operation
        op8(8'h0F, 8'h0F, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        q8.delete();
        #1;
        check("t5 rst busy", 32'(if8.busy), 32'd0);
        check("t5 rst done", 32'(if8.done), 32'd0);
        check("t5 rst sum", 32'(if8.sum), 32'd0);
        check("t5 rst cout", 32'(if8.cout), 32'd0);
        d0 = dn8;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        check("t5 no done", 32'(dn8 - d0), 32'd0);
        op8(8'h3C, 8'h0F, 1'b1);
        wait_done8();
        check("t5 fresh sum", 32'(if8.sum), 32'h2D);
        check("t5 fresh cout", 32'(if8.cout), 32'd1);

        // 6a: WIDTH=1, back-to-back random ops; operands scrambled while busy
        for (int n = 0; n < 1000; n++) begin
            if1.a = 1'($urandom); if1.b = 1'($urandom); if1.sub = 1'($urandom);
            if1.start = 1'b1;
            @(posedge clk);
            q1.push_back(model(1, {15'd0, if1.a}, {15'd0, if1.b}, if1.sub));
            for (int j = 0; j < 2; j++) begin
                #1;
                if1.a = 1'($urandom); if1.b = 1'($urandom); if1.sub = 1'($urandom);
                @(posedge clk);
            end
            #1;
        end
        if1.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("u1 queue drained", 32'(q1.size()), 32'd0);
        check("u1 done count", 32'(dn1), 32'd1000);

        // 6b: WIDTH=16, back-to-back random ops
        for (int n = 0; n < 1000; n++) begin
            if16.a = 16'($urandom); if16.b = 16'($urandom); if16.sub = 1'($urandom);
            if16.start = 1'b1;
            @(posedge clk);
            q16.push_back(model(16, if16.a, if16.b, if16.sub));
            for (int j = 0; j < 17; j++) begin
                #1;
                if16.a = 16'($urandom); if16.b = 16'($urandom); if16.sub = 1'($urandom);
                @(posedge clk);
            end
            #1;
        end
        if16.start = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        check("u16 queue drained", 32'(q16.size()), 32'd0);
        check("u16 done count", 32'(dn16), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
